// File: rtl/instruc_loader_pkg.sv
// Shared constants and state encoding for the UART-to-instruction-memory loader.
package instruc_loader_pkg;

  localparam int LD_BITS_SIZE  = 32;
  localparam int LD_SIZE_TOTAL = 256;
  localparam int LD_BYTE_SIZE  = 8;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/instruc_loader_if.sv
// Debug-unit side (start, RX bytes) and IF-memory side (write port, status) of the loader.
interface instruc_loader_if #(
  parameter int BITS_SIZE  = instruc_loader_pkg::LD_BITS_SIZE,
  parameter int SIZE_TOTAL = instruc_loader_pkg::LD_SIZE_TOTAL,
  parameter int BYTE_SIZE  = instruc_loader_pkg::LD_BYTE_SIZE
);
  localparam int CNT_W = $clog2(SIZE_TOTAL / 4) + 1;

  logic                 i_start;
  logic                 i_rx_valid;
  logic [BYTE_SIZE-1:0] i_rx_data;
  logic [BITS_SIZE-1:0] o_instruction_address;
  logic [BITS_SIZE-1:0] o_instruction;
  logic                 o_flag_write_intruc;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_overflow_err;
  logic [CNT_W-1:0]     o_instr_count;

  modport master (
    output i_start, i_rx_valid, i_rx_data,
    input  o_instruction_address, o_instruction, o_flag_write_intruc,
           o_busy, o_done, o_overflow_err, o_instr_count
  );

  modport slave (
    input  i_start, i_rx_valid, i_rx_data,
    output o_instruction_address, o_instruction, o_flag_write_intruc,
           o_busy, o_done, o_overflow_err, o_instr_count
  );
endinterface

// File: rtl/instruc_loader_word_assembler.sv
// Packs a big-endian byte stream into words; the completing byte is presented
// combinationally so the caller can latch the word on the same edge.
module instruc_loader_word_assembler #(
  parameter int BITS_SIZE = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [BYTE_SIZE-1:0] i_byte,
  output logic                 o_word_valid,
  output logic [BITS_SIZE-1:0] o_word
);
  localparam int NBYTES = BITS_SIZE / BYTE_SIZE;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int SH_W   = BITS_SIZE - BYTE_SIZE;

  logic [SH_W-1:0]  r_shift;
  logic [IDX_W-1:0] r_idx;
  logic             w_last;

  assign w_last       = (r_idx == IDX_W'(NBYTES - 1));
  assign o_word_valid = i_valid && w_last;
  assign o_word       = {r_shift, i_byte};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_valid) begin
      // Stale upper byte after a completed word is pushed out by the next three bytes.
      r_shift <= {r_shift[SH_W-BYTE_SIZE-1:0], i_byte};
      r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/instruc_loader.sv
// Loads instructions from the debug UART into IF instruction memory, starting at word 0,
// until the HALT word is written or memory is full.
module instruc_loader
  import instruc_loader_pkg::*;
#(
  parameter int BITS_SIZE  = LD_BITS_SIZE,
  parameter int SIZE_TOTAL = LD_SIZE_TOTAL,
  parameter int BYTE_SIZE  = LD_BYTE_SIZE
) (
  input  logic             i_clk,
  input  logic             i_reset,
  instruc_loader_if.slave  bus
);
  localparam int CNT_W = $clog2(SIZE_TOTAL / 4) + 1;

  loader_state_e        r_state, w_next;
  logic [BITS_SIZE-1:0] r_addr;
  logic [BITS_SIZE-1:0] r_iaddr;
  logic [BITS_SIZE-1:0] r_instr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_flag, r_busy, r_done, r_ovf;

  logic                 w_start, w_accept, w_word_valid;
  logic [BITS_SIZE-1:0] w_word, w_next_addr;
  logic                 w_halt, w_full;

  assign w_start     = bus.i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  // WRITE keeps accepting so a byte arriving during the write cycle starts the next word.
  assign w_accept    = (r_state == ST_RECV) || (r_state == ST_WRITE);
  assign w_next_addr = r_addr + BITS_SIZE'(4);
  assign w_halt      = (r_instr == BITS_SIZE'(HALT_WORD));
  assign w_full      = (w_next_addr == BITS_SIZE'(SIZE_TOTAL));

  instruc_loader_word_assembler #(
    .BITS_SIZE (BITS_SIZE),
    .BYTE_SIZE (BYTE_SIZE)
  ) u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_start),
    .i_valid      (bus.i_rx_valid && w_accept),
    .i_byte       (bus.i_rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start) w_next = ST_RECV;
      ST_RECV:          if (w_word_valid) w_next = ST_WRITE;
      ST_WRITE:         w_next = (w_halt || w_full) ? ST_DONE : ST_RECV;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_addr  <= '0;
      r_iaddr <= '0;
      r_instr <= '0;
      r_count <= '0;
      r_flag  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_flag <= 1'b0;
      r_busy <= (w_next == ST_RECV) || (w_next == ST_WRITE);
      if (w_start) begin
        r_addr  <= '0;
        r_count <= '0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
      end
      if (r_state == ST_RECV && w_word_valid) begin
        r_instr <= w_word;
        r_iaddr <= r_addr;
        r_flag  <= 1'b1;
      end
      if (r_state == ST_WRITE) begin
        r_addr  <= w_next_addr;
        r_count <= r_count + CNT_W'(1);
        if (w_halt || w_full) r_done <= 1'b1;
        if (!w_halt && w_full) r_ovf <= 1'b1;
      end
    end
  end

  assign bus.o_instruction_address = r_iaddr;
  assign bus.o_instruction         = r_instr;
  assign bus.o_flag_write_intruc   = r_flag;
  assign bus.o_busy                = r_busy;
  assign bus.o_done                = r_done;
  assign bus.o_overflow_err        = r_ovf;
  assign bus.o_instr_count         = r_count;
endmodule
